// File: rtl/level_loader_if.sv
// Avalon-MM write-port bundle between the level loader and the tile memory.
interface level_loader_if #(
  parameter int unsigned ADDR_W = 11
) ();

  logic              AVL_CS;
  logic              AVL_WRITE;
  logic              AVL_READ;
  logic [3:0]        AVL_BYTE_EN;
  logic [ADDR_W-1:0] AVL_ADDR;
  logic [31:0]       AVL_WRITEDATA;

  modport master (
    output AVL_CS, AVL_WRITE, AVL_READ, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA
  );

  modport slave (
    input AVL_CS, AVL_WRITE, AVL_READ, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA
  );

endinterface

// File: rtl/level_loader.sv
// Level loader: streams one level's tile map from the level ROM into tile
// memory, one word per clock, and reports done/error plus an XOR checksum.
module level_loader #(
  parameter int unsigned WORDS_PER_LEVEL = 75,
  parameter int unsigned NUM_LEVELS      = 8,
  parameter int unsigned ADDR_W          = 11,
  parameter int unsigned DST_BASE        = 0
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              start,
  input  logic [2:0]        level_sel,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_q,
  level_loader_if.master    avl
);

  localparam int unsigned CNT_W = $clog2(WORDS_PER_LEVEL + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WORDS_PER_LEVEL);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [31:0]       csum_q;
  logic [31:0]       acc_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  // Level offset in ROM/tile space; wraps in ADDR_W bits by design.
  logic [ADDR_W-1:0] lvl_off;
  assign lvl_off = ADDR_W'(level_sel) * ADDR_W'(WORDS_PER_LEVEL);

  // Control FSM with all outputs registered; ROM data lags rom_addr by one
  // clock, so FETCH primes the pipeline before the write burst starts.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q    <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      csum_q     <= '0;
      acc_q      <= '0;
      rom_addr_q <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      wr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (32'(level_sel) >= NUM_LEVELS) begin
              error_q <= 1'b1;
            end else begin
              base_q     <= lvl_off;
              rom_addr_q <= lvl_off;
              busy_q     <= 1'b1;
              acc_q      <= '0;
              cnt_q      <= '0;
              state_q    <= FETCH;
            end
          end
        end
        FETCH: begin
          rom_addr_q <= rom_addr_q + ADDR_W'(1);
          state_q    <= STREAM;
        end
        STREAM: begin
          if (cnt_q == CNT_END) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            csum_q  <= acc_q;
            state_q <= IDLE;
          end else begin
            wr_q       <= 1'b1;
            addr_q     <= ADDR_W'(DST_BASE) + base_q + ADDR_W'(cnt_q);
            wdata_q    <= rom_q;
            acc_q      <= acc_q ^ rom_q;
            rom_addr_q <= rom_addr_q + ADDR_W'(1);
            cnt_q      <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign checksum = csum_q;
  assign rom_addr = rom_addr_q;

  assign avl.AVL_CS        = wr_q;
  assign avl.AVL_WRITE     = wr_q;
  assign avl.AVL_READ      = 1'b0;
  assign avl.AVL_BYTE_EN   = wr_q ? 4'hF : 4'h0;
  assign avl.AVL_ADDR      = addr_q;
  assign avl.AVL_WRITEDATA = wdata_q;

endmodule

// File: tb/tb_level_loader.sv
// Directed bench for level_loader: default instance plus a NUM_LEVELS=5 one.
module tb_level_loader;

  localparam int unsigned AW = 11;

  logic          Clk = 1'b0;
  logic          RESET, start, start2;
  logic [2:0]    level_sel, level_sel2;
  logic          busy, done, error, busy2, done2, error2;
  logic [31:0]   checksum, checksum2, rom_q, rom_q2;
  logic [AW-1:0] rom_addr, rom_addr2;

  always #5 Clk = ~Clk;

  level_loader_if #(.ADDR_W(AW)) avl  ();
  level_loader_if #(.ADDR_W(AW)) avl2 ();

  level_loader #(.ADDR_W(AW)) u_dut (
    .Clk(Clk), .RESET(RESET), .start(start), .level_sel(level_sel),
    .busy(busy), .done(done), .error(error), .checksum(checksum),
    .rom_addr(rom_addr), .rom_q(rom_q), .avl(avl)
  );

  level_loader #(.NUM_LEVELS(5), .ADDR_W(AW)) u_dut5 (
    .Clk(Clk), .RESET(RESET), .start(start2), .level_sel(level_sel2),
    .busy(busy2), .done(done2), .error(error2), .checksum(checksum2),
    .rom_addr(rom_addr2), .rom_q(rom_q2), .avl(avl2)
  );

  // Synchronous level ROM: word k holds A000_0000 + k.
  always @(posedge Clk) begin
    rom_q  <= 32'hA000_0000 + 32'(rom_addr);
    rom_q2 <= 32'hA000_0000 + 32'(rom_addr2);
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  int            wc[$];
  int n_done, n_busy, n_bus_bad, n_w2;
  int n_chk = 0;
  int n_bad = 0;

  // Bus monitor, sampled on the falling edge.
  always @(negedge Clk) begin
    if (avl.AVL_WRITE) begin
      wa.push_back(avl.AVL_ADDR);
      wd.push_back(avl.AVL_WRITEDATA);
      wc.push_back(cyc);
      if (avl.AVL_BYTE_EN != 4'hF || !avl.AVL_CS || avl.AVL_READ) n_bus_bad++;
    end else if (avl.AVL_CS || avl.AVL_BYTE_EN != 4'h0 || avl.AVL_READ) begin
      n_bus_bad++;
    end
    if (done) n_done++;
    if (busy) n_busy++;
    if (avl2.AVL_WRITE) n_w2++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
    wc.delete();
    n_done = 0;
    n_busy = 0;
    n_bus_bad = 0;
  endtask

  task automatic launch(input logic [2:0] lvl, output int e);
    level_sel = lvl;
    start = 1'b1;
    tick();
    e = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dc);
    bit seen = 1'b0;
    dc = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        dc = cyc;
      end
    end
    if (!seen) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 300 && wa.size() < n; i++) tick();
    if (wa.size() < n) chk("write_timeout", 32'(wa.size()), 32'(n));
  endtask

  function automatic int burst_bad(input int idx, input int base);
    int bad = 0;
    if (wa.size() < idx + 75) return 75;
    for (int k = 0; k < 75; k++) begin
      if (wa[idx+k] !== AW'(base + k)) bad++;
      if (wd[idx+k] !== 32'hA000_0000 + 32'(base + k)) bad++;
    end
    return bad;
  endfunction

  function automatic logic [31:0] csum_model(input int base);
    logic [31:0] x = '0;
    for (int k = 0; k < 75; k++) x = x ^ (32'hA000_0000 + 32'(base + k));
    return x;
  endfunction

  function automatic int wcyc(input int idx);
    if (wc.size() <= idx) return -1;
    return wc[idx];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int e, e2, dc, snap;
    logic [31:0] ck2;
    RESET = 1'b1; start = 1'b0; start2 = 1'b0; level_sel = '0; level_sel2 = '0;
    repeat (3) tick();
    RESET = 1'b0;
    tick();

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_write", 32'(avl.AVL_WRITE), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_checksum", checksum, 32'd0);

    // Level 0: 75 writes at 0..74, first write two cycles after accept.
    clr();
    launch(3'd0, e);
    wait_done("t1", dc);
    chk("t1_nwrites", 32'(wa.size()), 32'd75);
    chk("t1_first_lat", 32'(wcyc(0) - e), 32'd2);
    chk("t1_done_lat", 32'(dc - e), 32'd77);
    chk("t1_busy_cycles", 32'(n_busy), 32'd77);
    chk("t1_words", 32'(burst_bad(0, 0)), 32'd0);
    chk("t1_checksum", checksum, 32'hA000_004B);
    chk("t1_ndone", 32'(n_done), 32'd1);
    chk("t1_bus", 32'(n_bus_bad), 32'd0);

    // Level 3: ROM and tile addresses start at 225.
    clr();
    launch(3'd3, e);
    chk("t2_rom_addr", 32'(rom_addr), 32'd225);
    wait_done("t2", dc);
    chk("t2_nwrites", 32'(wa.size()), 32'd75);
    chk("t2_words", 32'(burst_bad(0, 225)), 32'd0);
    chk("t2_busy_cycles", 32'(n_busy), 32'd77);
    chk("t2_checksum", checksum, csum_model(225));

    // NUM_LEVELS=5 instance: valid load, then an out-of-range request.
    level_sel2 = 3'd1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 300 && !done2; i++) tick();
    chk("t3_done2", 32'(done2), 32'd1);
    ck2 = csum_model(75);
    chk("t3_checksum_pre", checksum2, ck2);
    tick();
    snap = n_w2;
    level_sel2 = 3'd5;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("t3_error", 32'(error2), 32'd1);
    chk("t3_busy", 32'(busy2), 32'd0);
    tick();
    chk("t3_error_pulse", 32'(error2), 32'd0);
    repeat (5) tick();
    chk("t3_writes", 32'(n_w2 - snap), 32'd0);
    chk("t3_checksum_hold", checksum2, ck2);
    chk("t3_busy_after", 32'(busy2), 32'd0);

    // Level 1 with a second start mid-burst that must be ignored.
    clr();
    launch(3'd1, e);
    wait_writes(10);
    level_sel = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4", dc);
    repeat (10) tick();
    chk("t4_nwrites", 32'(wa.size()), 32'd75);
    chk("t4_words", 32'(burst_bad(0, 75)), 32'd0);
    chk("t4_ndone", 32'(n_done), 32'd1);

    // Reset mid-burst: writes stop, no done, checksum cleared.
    clr();
    launch(3'd2, e);
    wait_writes(30);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t5_write_off", 32'(avl.AVL_WRITE), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    repeat (100) tick();
    chk("t5_nwrites", 32'(wa.size()), 32'd30);
    chk("t5_ndone", 32'(n_done), 32'd0);
    chk("t5_checksum", checksum, 32'd0);
    clr();
    launch(3'd0, e);
    wait_done("t5b", dc);
    chk("t5_reload_words", 32'(burst_bad(0, 0)), 32'd0);
    chk("t5_reload_checksum", checksum, 32'hA000_004B);

    // Level 7, then level 2 started on the done cycle.
    clr();
    launch(3'd7, e);
    wait_done("t6a", dc);
    level_sel = 3'd2;
    start = 1'b1;
    tick();
    e2 = cyc;
    start = 1'b0;
    wait_done("t6b", dc);
    tick();
    chk("t6_nwrites", 32'(wa.size()), 32'd150);
    chk("t6_words_l7", 32'(burst_bad(0, 525)), 32'd0);
    chk("t6_words_l2", 32'(burst_bad(75, 150)), 32'd0);
    chk("t6_accept_gap", 32'(e2 - e), 32'd78);
    chk("t6_second_lat", 32'(wcyc(75) - e2), 32'd2);
    chk("t6_checksum", checksum, csum_model(150));
    chk("t6_ndone", 32'(n_done), 32'd2);
    chk("t6_bus", 32'(n_bus_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
